// File: rtl/prom_xfer_pkg.sv
// prom_xfer_pkg: shared state encoding and widths for the PROM-to-FIFO parameter transfer
package prom_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT_DV = 3'd2,
        WRITE   = 3'd3,
        STALL   = 3'd4,
        DONE    = 3'd5
    } xfer_state_e;

    localparam int WORD_W   = 16;
    localparam int CRC_WRDS = 2;

endpackage

// File: rtl/prom_param_xfer.sv
// prom_param_xfer: copies one parameter block from the serial-PROM read port into the slow parameter FIFO
module prom_param_xfer
    import prom_xfer_pkg::*;
#(
    parameter logic [8:0]  MAX_WRDS  = 9'd34,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [7:0]  TMO_CYC   = 8'd255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              AL_PROM2FF,
    input  logic              CRC,
    output logic              PROM_RD_REQ,
    output logic [15:0]       PROM_ADDR,
    input  logic [WORD_W-1:0] PROM_DATA,
    input  logic              PROM_DV,
    output logic              FF_WE,
    output logic [WORD_W-1:0] FF_DIN,
    input  logic              FF_FULL,
    output logic              XFER_DONE,
    output logic              XFER_ERR,
    output logic [5:0]        XFER_CNT,
    output logic [2:0]        XFER_STATE
);

    localparam logic [5:0] MAX6 = MAX_WRDS[5:0];

    xfer_state_e state, nxt;
    logic        start_pend, start;
    logic [5:0]  n_wrds, cnt_nxt;
    logic [7:0]  tmo, tmo_nxt;

    assign start      = state == IDLE && (start_pend || AL_PROM2FF);
    assign XFER_STATE = state;

    always_comb begin
        nxt     = state;
        cnt_nxt = XFER_CNT;
        tmo_nxt = tmo;
        case (state)
            IDLE: if (start) begin
                nxt     = REQ;
                cnt_nxt = '0;
                tmo_nxt = '0;
            end
            REQ: begin
                nxt     = WAIT_DV;
                tmo_nxt = '0;
            end
            WAIT_DV: begin
                tmo_nxt = tmo + 8'd1;
                nxt     = PROM_DV ? (FF_FULL ? STALL : WRITE) : (tmo_nxt == TMO_CYC ? DONE : WAIT_DV);
            end
            STALL: nxt = FF_FULL ? STALL : WRITE;
            WRITE: begin
                cnt_nxt = XFER_CNT == 6'd63 ? XFER_CNT : XFER_CNT + 6'd1;
                nxt     = cnt_nxt == n_wrds ? DONE : REQ;
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Strobes and address are registered from the next state so they line up exactly with REQ/WRITE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            start_pend  <= 1'b1;
            n_wrds      <= MAX6;
            tmo         <= '0;
            XFER_CNT    <= '0;
            XFER_DONE   <= 1'b0;
            XFER_ERR    <= 1'b0;
            PROM_RD_REQ <= 1'b0;
            PROM_ADDR   <= BASE_ADDR;
            FF_WE       <= 1'b0;
            FF_DIN      <= '0;
        end else begin
            state       <= nxt;
            tmo         <= tmo_nxt;
            XFER_CNT    <= cnt_nxt;
            start_pend  <= start ? 1'b0 : (AL_PROM2FF && state == DONE) ? 1'b1 : start_pend;
            n_wrds      <= start ? (CRC ? MAX6 + 6'(CRC_WRDS) : MAX6) : n_wrds;
            PROM_RD_REQ <= nxt == REQ;
            PROM_ADDR   <= nxt == REQ ? BASE_ADDR + {10'd0, cnt_nxt} : PROM_ADDR;
            FF_WE       <= nxt == WRITE;
            FF_DIN      <= (state == WAIT_DV && PROM_DV) ? PROM_DATA : FF_DIN;
            XFER_DONE   <= nxt == DONE ? 1'b1 : start ? 1'b0 : XFER_DONE;
            XFER_ERR    <= (state == WAIT_DV && nxt == DONE) ? 1'b1 : start ? 1'b0 : XFER_ERR;
        end
    end

endmodule
